// File: rtl/match_search_sequencer.sv
// Candidate sequencer for an external equality comparator: sweeps [lo, hi] one value per clock,
// stops on the first match, on abort or at hi, and reports the outcome and candidates tested.
module match_search_sequencer #(
    parameter int LENGTH = 22,
    parameter int CNT_W  = LENGTH + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [LENGTH-1:0] lo,
    input  logic [LENGTH-1:0] hi,
    output logic [LENGTH-1:0] cand,
    output logic              cand_valid,
    input  logic              eq_in,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic              aborted,
    output logic [LENGTH-1:0] match_value,
    output logic [CNT_W-1:0]  tested
);

    localparam logic [LENGTH-1:0] CandOne = 1;
    localparam logic [CNT_W-1:0]  CntOne  = 1;

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_t;

    state_t            state_q, state_d;
    logic [LENGTH-1:0] hi_q, hi_d;
    logic [LENGTH-1:0] cand_q, cand_d;
    logic [LENGTH-1:0] match_q, match_d;
    logic [CNT_W-1:0]  tested_q, tested_d;
    logic              found_q, found_d;
    logic              aborted_q, aborted_d;
    logic              done_q, done_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            hi_q      <= '0;
            cand_q    <= '0;
            match_q   <= '0;
            tested_q  <= '0;
            found_q   <= 1'b0;
            aborted_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            cand_q    <= cand_d;
            match_q   <= match_d;
            tested_q  <= tested_d;
            found_q   <= found_d;
            aborted_q <= aborted_d;
            done_q    <= done_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        cand_d    = cand_q;
        match_d   = match_q;
        tested_d  = tested_q;
        found_d   = found_q;
        aborted_d = aborted_q;
        done_d    = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    found_d   = 1'b0;
                    aborted_d = 1'b0;
                    tested_d  = '0;
                    if (lo <= hi) begin
                        hi_d    = hi;
                        cand_d  = lo;
                        state_d = StRun;
                    end else begin
                        // Empty range: report completion without driving any candidate.
                        done_d = 1'b1;
                    end
                end
            end
            StRun: begin
                if (abort) begin
                    aborted_d = 1'b1;
                    found_d   = 1'b0;
                    done_d    = 1'b1;
                    state_d   = StDone;
                end else begin
                    tested_d = tested_q + CntOne;
                    if (eq_in) begin
                        found_d = 1'b1;
                        match_d = cand_q;
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else if (cand_q == hi_q) begin
                        // Checked before incrementing so cand never wraps past hi.
                        done_d  = 1'b1;
                        state_d = StDone;
                    end else begin
                        cand_d = cand_q + CandOne;
                    end
                end
            end
            StDone: state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    assign cand        = cand_q;
    assign cand_valid  = (state_q == StRun);
    assign busy        = (state_q == StRun);
    assign done        = done_q;
    assign found       = found_q;
    assign aborted     = aborted_q;
    assign match_value = match_q;
    assign tested      = tested_q;

endmodule
